// File: rtl/isa_burst_reader_if.sv
// Bundles the cache-side fetch port and the DDR burst-read port of isa_burst_reader.
// The slave modport is the reader itself; master is the cache/DDR environment.
interface isa_burst_reader_if #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30
);
  logic                      ISA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
  logic [9:0]                isa_read_len;
  logic [ISA_WIDTH-1:0]      instruction_to_cache;
  logic [9:0]                rd_cnt_isa;
  logic                      rd_burst_data_valid;
  logic                      isa_rd_busy;
  logic                      isa_rd_err;
  logic                      rd_burst_req;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [9:0]                rd_burst_len;
  logic                      rd_burst_ack;
  logic [DDR_DATA_WIDTH-1:0] rd_burst_data;
  logic                      rd_burst_data_valid_ddr;
  logic                      rd_burst_finish;

  modport slave (
    input  ISA_read_req, ISA_read_addr, isa_read_len,
    input  rd_burst_ack, rd_burst_data, rd_burst_data_valid_ddr, rd_burst_finish,
    output instruction_to_cache, rd_cnt_isa, rd_burst_data_valid, isa_rd_busy, isa_rd_err,
    output rd_burst_req, rd_burst_addr, rd_burst_len
  );

  modport master (
    output ISA_read_req, ISA_read_addr, isa_read_len,
    output rd_burst_ack, rd_burst_data, rd_burst_data_valid_ddr, rd_burst_finish,
    input  instruction_to_cache, rd_cnt_isa, rd_burst_data_valid, isa_rd_busy, isa_rd_err,
    input  rd_burst_req, rd_burst_addr, rd_burst_len
  );
endinterface

// File: rtl/isa_burst_reader.sv
// Instruction-fetch DDR read engine: splits one cache fetch into bounded DDR bursts
// and streams back one instruction per DDR word with a running count.
module isa_burst_reader #(
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int ISA_WIDTH      = 30,
  parameter int MAX_BURST_LEN  = 64,
  parameter int ADDR_STEP      = 8
) (
  input logic               clk,
  input logic               rst,
  isa_burst_reader_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_NEXT, S_DONE} state_t;

  localparam logic [9:0]                MAX_LEN = 10'(MAX_BURST_LEN);
  localparam logic [DDR_ADDR_WIDTH-1:0] STEP    = DDR_ADDR_WIDTH'(ADDR_STEP);

  state_t                    state_q, state_d;
  logic [DDR_ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [9:0]                len_q, len_d, cnt_q, cnt_d;
  logic [9:0]                bcnt_q, bcnt_d, blen_q, blen_d;
  logic [ISA_WIDTH-1:0]      instr_q, instr_d;
  logic                      strobe_q, strobe_d, busy_q, busy_d;
  logic                      err_q, err_d, req_q, req_d;

  function automatic logic [9:0] clamp_len(input logic [9:0] remaining);
    return (remaining > MAX_LEN) ? MAX_LEN : remaining;
  endfunction

  function automatic logic [DDR_ADDR_WIDTH-1:0] burst_addr(
    input logic [DDR_ADDR_WIDTH-1:0] base, input logic [9:0] done);
    return base + DDR_ADDR_WIDTH'(done) * STEP;
  endfunction

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    bcnt_d   = bcnt_q;
    blen_d   = blen_q;
    instr_d  = instr_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    req_d    = req_q;
    case (state_q)
      S_IDLE: if (bus.ISA_read_req) begin
        base_d = bus.ISA_read_addr;
        len_d  = bus.isa_read_len;
        cnt_d  = '0;
        err_d  = 1'b0;
        if (bus.isa_read_len == 10'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_REQ;
          busy_d  = 1'b1;
          req_d   = 1'b1;
          addr_d  = bus.ISA_read_addr;
          blen_d  = clamp_len(bus.isa_read_len);
        end
      end
      S_REQ: if (bus.rd_burst_ack) begin
        req_d   = 1'b0;
        bcnt_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        // Words past the burst or past the whole fetch are silently dropped.
        if (bus.rd_burst_data_valid_ddr && (bcnt_q < blen_q) && (cnt_q < len_q)) begin
          instr_d  = bus.rd_burst_data[ISA_WIDTH-1:0];
          cnt_d    = cnt_q + 10'd1;
          bcnt_d   = bcnt_q + 10'd1;
          strobe_d = 1'b1;
        end
        // Same-cycle word is already folded into bcnt_d/cnt_d before judging the finish.
        if (bus.rd_burst_finish) begin
          if (bcnt_d < blen_q) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else if (cnt_d == len_q) begin
            busy_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        state_d = S_REQ;
        req_d   = 1'b1;
        addr_d  = burst_addr(base_q, cnt_q);
        blen_d  = clamp_len(len_q - cnt_q);
      end
      S_DONE: if (!bus.ISA_read_req) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      blen_q   <= '0;
      instr_q  <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      blen_q   <= blen_d;
      instr_q  <= instr_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      req_q    <= req_d;
    end
  end

  assign bus.instruction_to_cache = instr_q;
  assign bus.rd_cnt_isa           = cnt_q;
  assign bus.rd_burst_data_valid  = strobe_q;
  assign bus.isa_rd_busy          = busy_q;
  assign bus.isa_rd_err           = err_q;
  assign bus.rd_burst_req         = req_q;
  assign bus.rd_burst_addr        = addr_q;
  assign bus.rd_burst_len         = blen_q;
endmodule

// File: tb/tb_isa_burst_reader.sv
// Directed bench for isa_burst_reader: a DDR responder pushes expected strobes and
// bursts into queues that an independent monitor pops and compares.
module tb_isa_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  isa_burst_reader_if #(.DDR_ADDR_WIDTH(28), .DDR_DATA_WIDTH(64), .ISA_WIDTH(30)) bus ();

  isa_burst_reader #(
    .DDR_ADDR_WIDTH(28), .DDR_DATA_WIDTH(64), .ISA_WIDTH(30),
    .MAX_BURST_LEN(64), .ADDR_STEP(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { logic [29:0] instr; logic [9:0] cnt; } exp_t;
  typedef struct { logic [27:0] addr; logic [9:0] len; } bexp_t;

  exp_t  exp_q[$];
  bexp_t bq[$];
  int    checks = 0;
  int    errors = 0;
  int    tb_cnt = 0;
  logic  prev_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic push_burst(input logic [27:0] a, input logic [9:0] l);
    bexp_t b;
    b.addr = a;
    b.len  = l;
    bq.push_back(b);
  endtask

  task automatic start_fetch(input logic [27:0] a, input logic [9:0] l);
    @(negedge clk);
    bus.ISA_read_req  = 1'b1;
    bus.ISA_read_addr = a;
    bus.isa_read_len  = l;
    tb_cnt = 0;
    @(negedge clk);
    bus.ISA_read_addr = 28'hFFFFFF0;
    bus.isa_read_len  = 10'd3;
  endtask

  task automatic drop_req();
    @(negedge clk);
    bus.ISA_read_req = 1'b0;
    @(negedge clk);
    chk("cnt_cleared_in_idle", bus.rd_cnt_isa, 0);
  endtask

  // Serves one burst: waits for the request, acks after ack_dly cycles, returns nwords.
  task automatic ddr_burst(input int nwords, input int ack_dly, input bit gap,
                           input int seed, input bit fin);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (!bus.rd_burst_req && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL burst_req_timeout: got no request after %0d cycles", t);
      return;
    end
    repeat (ack_dly) @(negedge clk);
    bus.rd_burst_ack = 1'b1;
    @(negedge clk);
    bus.rd_burst_ack = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      if (gap && i > 0) begin
        bus.rd_burst_data_valid_ddr = 1'b0;
        @(negedge clk);
      end
      bus.rd_burst_data           = {32'hDEADBEEF, 2'b11, 30'(seed + i)};
      bus.rd_burst_data_valid_ddr = 1'b1;
      bus.rd_burst_finish         = fin && (i == nwords - 1);
      e.instr = 30'(seed + i);
      e.cnt   = 10'(tb_cnt + 1);
      exp_q.push_back(e);
      tb_cnt++;
      @(negedge clk);
    end
    bus.rd_burst_data_valid_ddr = 1'b0;
    bus.rd_burst_finish         = 1'b0;
  endtask

  initial begin
    bus.ISA_read_req            = 1'b0;
    bus.ISA_read_addr           = '0;
    bus.isa_read_len            = '0;
    bus.rd_burst_ack            = 1'b0;
    bus.rd_burst_data           = '0;
    bus.rd_burst_data_valid_ddr = 1'b0;
    bus.rd_burst_finish         = 1'b0;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          #1;
          if (bus.rd_burst_data_valid) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_strobe: instr 0x%0h cnt %0d with nothing expected",
                       bus.instruction_to_cache, bus.rd_cnt_isa);
            end else begin
              e = exp_q.pop_front();
              chk("instr", bus.instruction_to_cache, e.instr);
              chk("rd_cnt", bus.rd_cnt_isa, e.cnt);
              chk("strobe_latency", prev_vld, 1);
            end
          end
          if (bus.rd_burst_req) begin
            if (bq.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_req: addr 0x%0h len %0d with nothing expected",
                       bus.rd_burst_addr, bus.rd_burst_len);
            end else begin
              chk("burst_addr", bus.rd_burst_addr, bq[0].addr);
              chk("burst_len", bus.rd_burst_len, bq[0].len);
              if (bus.rd_burst_ack) void'(bq.pop_front());
            end
          end
          prev_vld = bus.rd_burst_data_valid_ddr;
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
      end
      begin : main
        repeat (3) @(negedge clk);
        chk("reset_out_a", {bus.instruction_to_cache, bus.rd_cnt_isa, bus.rd_burst_data_valid,
                            bus.isa_rd_busy, bus.isa_rd_err, bus.rd_burst_req}, 0);
        chk("reset_out_b", {bus.rd_burst_addr, bus.rd_burst_len}, 0);
        rst = 1'b0;

        // Single burst of 16
        push_burst(28'h100, 10'd16);
        start_fetch(28'h100, 10'd16);
        chk("t1_busy", bus.isa_rd_busy, 1);
        ddr_burst(16, 0, 1'b0, 100, 1'b1);
        chk("t1_done_busy", bus.isa_rd_busy, 0);
        chk("t1_done_cnt", bus.rd_cnt_isa, 16);
        repeat (3) @(negedge clk);
        chk("t1_hold_cnt", bus.rd_cnt_isa, 16);
        chk("t1_hold_instr", bus.instruction_to_cache, 30'd115);
        drop_req();

        // Split fetch of 128 into two bursts of 64
        push_burst(28'h000, 10'd64);
        push_burst(28'h200, 10'd64);
        start_fetch(28'h000, 10'd128);
        ddr_burst(64, 1, 1'b0, 1000, 1'b1);
        chk("t2_next_req_low", bus.rd_burst_req, 0);
        @(negedge clk);
        chk("t2_next_req_high", bus.rd_burst_req, 1);
        ddr_burst(64, 0, 1'b0, 1064, 1'b1);
        chk("t2_done_cnt", bus.rd_cnt_isa, 128);
        chk("t2_done_busy", bus.isa_rd_busy, 0);
        drop_req();

        // Ack stall and gapped data
        push_burst(28'h040, 10'd10);
        start_fetch(28'h040, 10'd10);
        ddr_burst(10, 5, 1'b1, 2000, 1'b1);
        chk("t3_done_cnt", bus.rd_cnt_isa, 10);
        chk("t3_err", bus.isa_rd_err, 0);
        drop_req();

        // Short burst: 5 of 8 words
        push_burst(28'h800, 10'd8);
        start_fetch(28'h800, 10'd8);
        ddr_burst(5, 0, 1'b0, 3000, 1'b1);
        @(negedge clk);
        chk("t4_cnt", bus.rd_cnt_isa, 5);
        chk("t4_err", bus.isa_rd_err, 1);
        chk("t4_busy", bus.isa_rd_busy, 0);
        drop_req();
        chk("t4_err_sticky_idle", bus.isa_rd_err, 1);
        push_burst(28'h010, 10'd2);
        start_fetch(28'h010, 10'd2);
        chk("t4_err_cleared", bus.isa_rd_err, 0);
        ddr_burst(2, 0, 1'b0, 4000, 1'b1);
        chk("t4_refetch_cnt", bus.rd_cnt_isa, 2);
        drop_req();

        // Zero length with request held
        start_fetch(28'h123, 10'd0);
        chk("t5_busy", bus.isa_rd_busy, 0);
        repeat (6) @(negedge clk);
        chk("t5_busy_held", bus.isa_rd_busy, 0);
        chk("t5_cnt", bus.rd_cnt_isa, 0);
        chk("t5_req", bus.rd_burst_req, 0);
        drop_req();

        // Reset after 3 of 16 words
        push_burst(28'h300, 10'd16);
        start_fetch(28'h300, 10'd16);
        ddr_burst(3, 0, 1'b0, 5000, 1'b0);
        rst = 1'b1;
        bus.ISA_read_req = 1'b0;
        @(negedge clk);
        chk("t6_rst_out_a", {bus.instruction_to_cache, bus.rd_cnt_isa, bus.rd_burst_data_valid,
                             bus.isa_rd_busy, bus.isa_rd_err, bus.rd_burst_req}, 0);
        chk("t6_rst_out_b", {bus.rd_burst_addr, bus.rd_burst_len}, 0);
        rst = 1'b0;
        push_burst(28'h300, 10'd4);
        start_fetch(28'h300, 10'd4);
        ddr_burst(4, 0, 1'b0, 6000, 1'b1);
        chk("t6_refetch_cnt", bus.rd_cnt_isa, 4);
        drop_req();

        repeat (4) @(negedge clk);
        chk("strobes_left", exp_q.size(), 0);
        chk("bursts_left", bq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end
endmodule
